// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard stall/flush controller.
package hazard_pkg;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         MD_CNT_W = 4;

  // True when a nonzero producer register feeds either consumer operand.
  function automatic logic reg_match(input logic [4:0] producer,
                                     input logic [4:0] src_a,
                                     input logic [4:0] src_b);
    return (producer != REG_ZERO) && ((producer == src_a) || (producer == src_b));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard stall unit: stage operands in, stall/flush and debug counters out.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic [4:0]       Rt_EX;
  logic [4:0]       WriteReg_EX;
  logic [4:0]       WriteReg_M;
  logic             RegWrite_EX;
  logic             MemtoReg_EX;
  logic             MemtoReg_M;
  logic             Branch_ID;
  logic             PCSrc_D;
  logic             MDStart_EX;
  logic             MDUse_ID;
  logic             ctr_clr;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] load_stall_cnt;
  logic [CNT_W-1:0] branch_stall_cnt;
  logic [CNT_W-1:0] md_stall_cnt;

  modport master (
    output Rs_ID, Rt_ID, Rt_EX, WriteReg_EX, WriteReg_M,
    output RegWrite_EX, MemtoReg_EX, MemtoReg_M, Branch_ID, PCSrc_D,
    output MDStart_EX, MDUse_ID, ctr_clr,
    input  StallF, StallD, FlushD, FlushE,
    input  load_stall_cnt, branch_stall_cnt, md_stall_cnt
  );

  modport slave (
    input  Rs_ID, Rt_ID, Rt_EX, WriteReg_EX, WriteReg_M,
    input  RegWrite_EX, MemtoReg_EX, MemtoReg_M, Branch_ID, PCSrc_D,
    input  MDStart_EX, MDUse_ID, ctr_clr,
    output StallF, StallD, FlushD, FlushE,
    output load_stall_cnt, branch_stall_cnt, md_stall_cnt
  );

endinterface

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// Tracks how long the multi-cycle multiply/divide unit stays busy after an issue.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MD_LAT_V = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  md_state_e           state_q, state_d;

  // A new issue always restarts the countdown, even mid-busy.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = MD_LAT_V;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
    state_d = (md_cnt_d != '0) ? MD_BUSY : MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
      state_q  <= MD_IDLE;
    end else begin
      md_cnt_q <= md_cnt_d;
      state_q  <= state_d;
    end
  end

  assign md_busy = md_start | (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline covering hazards that bypassing cannot resolve.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic                 clk,
  input logic                 reset,
  hazard_stall_unit_if.slave  hif
);

  logic             md_busy;
  logic             lwstall, brstall, mdstall, stall;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_tracker (
    .clk      (clk),
    .reset    (reset),
    .md_start (hif.MDStart_EX),
    .md_busy  (md_busy)
  );

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic             hit,
                                            input logic             clr);
    if (clr) return '0;
    if (hit && (cnt != '1)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  // A branch resolved on stale operands is discarded, so the flush waits until the stall clears.
  always_comb begin
    lwstall = hif.MemtoReg_EX & reg_match(hif.Rt_EX, hif.Rs_ID, hif.Rt_ID);
    brstall = hif.Branch_ID &
              ((hif.RegWrite_EX & reg_match(hif.WriteReg_EX, hif.Rs_ID, hif.Rt_ID)) |
               (hif.MemtoReg_M  & reg_match(hif.WriteReg_M,  hif.Rs_ID, hif.Rt_ID)));
    mdstall = hif.MDUse_ID & md_busy;
    stall   = lwstall | brstall | mdstall;

    hif.StallF = stall & ~reset;
    hif.StallD = stall & ~reset;
    hif.FlushE = stall & ~reset;
    hif.FlushD = hif.PCSrc_D & ~stall & ~reset;
  end

  always_comb begin
    load_cnt_d   = bump(load_cnt_q,   lwstall, hif.ctr_clr);
    branch_cnt_d = bump(branch_cnt_q, brstall, hif.ctr_clr);
    md_cnt_d     = bump(md_cnt_q,     mdstall, hif.ctr_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q   <= '0;
      branch_cnt_q <= '0;
      md_cnt_q     <= '0;
    end else begin
      load_cnt_q   <= load_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      md_cnt_q     <= md_cnt_d;
    end
  end

  assign hif.load_stall_cnt   = load_cnt_q;
  assign hif.branch_stall_cnt = branch_cnt_q;
  assign hif.md_stall_cnt     = md_cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; the counterpart to forwarding.
- Forwarding resolves dependencies by bypassing values. This block resolves the dependencies that bypassing cannot cover:
  - load-use in EX;
  - branch operands not yet available at the decode-stage comparator;
  - HI/LO use while the multi-cycle multiply/divide unit is busy.
- Drives StallF, StallD, FlushD and FlushE, and keeps saturating per-cause stall counters for performance debug.

Parameters:
- MD_LATENCY, 4: extra busy cycles of the multiply/divide unit after issue; legal range 1..15.
- CNT_W, 32: width of each stall counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- Rs_ID  in  5  rs of the instruction in decode
- Rt_ID  in  5  rt of the instruction in decode
- Rt_EX  in  5  rt of the instruction in execute
- WriteReg_EX  in  5  destination register in execute
- WriteReg_M  in  5  destination register in memory
- RegWrite_EX  in  1  execute-stage instruction writes the register file
- MemtoReg_EX  in  1  execute-stage instruction is a load
- MemtoReg_M  in  1  memory-stage instruction is a load
- Branch_ID  in  1  decode-stage instruction is BEQ/BNE
- PCSrc_D  in  1  branch taken, as decided in decode
- MDStart_EX  in  1  mult/div issuing in execute this cycle
- MDUse_ID  in  1  decode-stage instruction is mfhi/mflo/mult/div
- ctr_clr  in  1  synchronous clear of the stall counters
- StallF  out  1  hold PC
- StallD  out  1  hold the IF/ID register
- FlushD  out  1  clear the IF/ID register
- FlushE  out  1  clear the ID/EX register (insert a bubble)
- load_stall_cnt  out  CNT_W  cycles stalled for load-use
- branch_stall_cnt  out  CNT_W  cycles stalled for branch operands
- md_stall_cnt  out  CNT_W  cycles stalled for multiply/divide busy

Behaviour:
- Stall causes (combinational, same cycle):
  - lwstall = MemtoReg_EX & (Rt_EX != 0) & (Rt_EX == Rs_ID | Rt_EX == Rt_ID)
  - brstall = Branch_ID & [ (RegWrite_EX & WriteReg_EX != 0 & WriteReg_EX matches Rs_ID or Rt_ID) | (MemtoReg_M & WriteReg_M != 0 & WriteReg_M matches Rs_ID or Rt_ID) ]
  - mdstall = MDUse_ID & md_busy
- Outputs:
  - stall = lwstall | brstall | mdstall
  - StallF = StallD = FlushE = stall
  - FlushD = PCSrc_D & ~stall, because a branch decision made on stale operands is ignored.
- While reset is high, all four control outputs are forced to 0.
- Multiply/divide tracker:
  - 4-bit down-counter md_cnt; FSM state MD_IDLE when md_cnt == 0, MD_BUSY otherwise.
  - md_busy = MDStart_EX | (md_cnt != 0).
  - MD_IDLE: MDStart_EX loads md_cnt = MD_LATENCY and moves to MD_BUSY.
  - MD_BUSY: md_cnt decrements each cycle; it reaches 0 and returns to MD_IDLE after MD_LATENCY cycles.
  - MDStart_EX while in MD_BUSY reloads MD_LATENCY (restart). This is only defensive, since MDUse_ID covers mult/div issue.
  - Net effect: if a mult issues in cycle t, an HI/LO user in decode stalls in cycles t..t+MD_LATENCY and proceeds at t+MD_LATENCY+1.
- Counters:
  - Each counter increments by 1 on a clock edge where its own cause is high. Simultaneous causes each increment.
  - Counters saturate at all-ones.
  - ctr_clr zeroes all three counters, taking priority over increment.
- Reset:
  - Sets md_cnt = 0 (MD_IDLE) and all counters to 0; reset has priority over ctr_clr and MDStart_EX.
  - Reset mid-busy aborts tracking immediately: the first cycle after reset has md_busy = MDStart_EX only.
- Register 0 never causes a stall.

Decomposition:
- Shared package hazard_pkg holds:
  - state type (MD_IDLE, MD_BUSY);
  - REG_ZERO constant (5'd0);
  - MD_CNT_W constant (4).
- One sub-module, md_busy_tracker, contains the counter/FSM and the md_busy output. Stall logic and counters stay in the top module.

Test Plan:
- Load-use: lw $8 in EX (Rt_EX=8, MemtoReg_EX=1), Rs_ID=8 -> StallF=StallD=FlushE=1 for exactly one cycle; load_stall_cnt 0->1. Same case with Rt_EX=0 -> no stall.
- Branch after ALU op: Branch_ID=1, Rt_ID=5, RegWrite_EX=1, WriteReg_EX=5, PCSrc_D=1 -> stall=1 and FlushD=0. Next cycle, with no EX match -> stall=0, FlushD=1; branch_stall_cnt=1.
- Branch after load in MEM: MemtoReg_M=1, WriteReg_M=3, Rs_ID=3, Branch_ID=1 -> one stall cycle. Same case with Branch_ID=0 -> no stall.
- Multiply busy, MD_LATENCY=4: MDStart_EX at cycle 10 with MDUse_ID held high from cycle 10 -> stall high in cycles 10..14, low at 15; md_stall_cnt=5.
- Reset mid-busy: MDStart_EX at cycle 0, reset at cycle 2 with MDUse_ID=1 -> outputs 0 during reset, no stall afterward, all counters 0.
- Saturation/clear, with CNT_W=4: hold lwstall 20 cycles -> load_stall_cnt=15. ctr_clr together with lwstall -> 0.
